spike_event_encoder: RTL and testbench

Downstream consumer of the neuron core's membrane potential. Compares the signed Q3.12 `v` stream against a programmable threshold each cycle and detects spikes using a refractory timer and a hysteresis re-arm level. Each spike is tagged with a free-running timestamp and its membrane value, then queued in a small show-ahead FIFO drained over a valid/ready handshake. A saturating spike counter and a sticky overflow flag are provided for monitoring.

---
 rtl/spike_event_encoder.sv | 182 ++++++++++++++++++
 tb/tb_spike_event_encoder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/spike_event_encoder.sv
// rtl/spike_event_encoder.sv - threshold spike detector with refractory/hysteresis and timestamped event FIFO
//
// Compares the signed fixed-point membrane potential against a threshold and,
// on a detect, queues {timestamp, v_in} in a show-ahead FIFO drained by a
// valid/ready handshake. A refractory timer followed by a hysteresis re-arm
// level stops one excursion above threshold from producing a burst of events.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   en                  detection/timestamp enable (FSM, rcnt and ts hold when low)
//   v_in                signed membrane potential sample
//   thresh              signed spike threshold (detect when v_in >= thresh)
//   rearm_level         signed re-arm level (re-arm when v_in < rearm_level)
//   clr_count           synchronous clear of spike_count and overflow
//   evt_valid/evt_ready head-of-queue handshake
//   evt_ts, evt_v       registered head entry, zero when the queue is empty
//   spike_count         saturating count of detects
//   overflow            sticky, set when a detect found the queue full without a pop
module spike_event_encoder #(
    parameter int int_width     = 3,
    parameter int frc_width     = 12,
    parameter int TS_WIDTH      = 16,
    parameter int FIFO_DEPTH    = 8,
    parameter int REFRAC_CYCLES = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                en,
    input  logic signed [int_width+frc_width:0] v_in,
    input  logic signed [int_width+frc_width:0] thresh,
    input  logic signed [int_width+frc_width:0] rearm_level,
    input  logic                                clr_count,
    output logic                                evt_valid,
    input  logic                                evt_ready,
    output logic [TS_WIDTH-1:0]                 evt_ts,
    output logic signed [int_width+frc_width:0] evt_v,
    output logic [15:0]                         spike_count,
    output logic                                overflow
);
    localparam int w  = 1 + int_width + frc_width;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int RW = (REFRAC_CYCLES > 1) ? $clog2(REFRAC_CYCLES + 1) : 1;
    localparam int EW = TS_WIDTH + w;

    typedef enum logic [1:0] {ARMED, REFRAC, REARM} state_t;

    state_t          state, state_nxt;
    logic [RW-1:0]   rcnt, rcnt_nxt;
    logic [TS_WIDTH-1:0] ts;
    logic            detect;

    logic [EW-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr, rd_ptr_inc;
    logic [AW:0]     occ, occ_nxt;
    logic [EW-1:0]   head_nxt, push_data;
    logic            full, pop, push_ok, drop;

    always_comb begin
        state_nxt = state;
        rcnt_nxt  = rcnt;
        detect    = 1'b0;
        case (state)
            ARMED: begin
                if (en && (v_in >= thresh)) begin
                    detect = 1'b1;
                    if (REFRAC_CYCLES == 0) begin
                        state_nxt = REARM;
                    end else begin
                        state_nxt = REFRAC;
                        rcnt_nxt  = RW'(REFRAC_CYCLES);
                    end
                end
            end
            REFRAC: begin
                // The decrement that takes rcnt to zero also leaves the state.
                if (en) begin
                    if (rcnt <= RW'(1)) begin
                        state_nxt = REARM;
                        rcnt_nxt  = '0;
                    end else begin
                        rcnt_nxt = rcnt - RW'(1);
                    end
                end
            end
            REARM: begin
                if (en && (v_in < rearm_level)) begin
                    state_nxt = ARMED;
                end
            end
            default: state_nxt = ARMED;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARMED;
            rcnt  <= '0;
            ts    <= '0;
        end else begin
            state <= state_nxt;
            rcnt  <= rcnt_nxt;
            if (en) begin
                ts <= ts + TS_WIDTH'(1);
            end
        end
    end

    // A pop frees the slot the push lands in, so a full queue still accepts.
    assign full       = (occ == (AW+1)'(FIFO_DEPTH));
    assign pop        = evt_valid && evt_ready;
    assign push_ok    = detect && (!full || pop);
    assign drop       = detect && full && !pop;
    assign push_data  = {ts, v_in};
    assign rd_ptr_inc = rd_ptr + AW'(1);

    always_comb begin
        occ_nxt = occ;
        case ({push_ok, pop})
            2'b10:   occ_nxt = occ + (AW+1)'(1);
            2'b01:   occ_nxt = occ - (AW+1)'(1);
            default: occ_nxt = occ;
        endcase
    end

    // Head registers only change on a pop or on a push into an empty queue.
    always_comb begin
        head_nxt = {evt_ts, evt_v};
        if (pop) begin
            if (occ == (AW+1)'(1)) begin
                head_nxt = push_ok ? push_data : '0;
            end else begin
                head_nxt = mem[rd_ptr_inc];
            end
        end else if ((occ == '0) && push_ok) begin
            head_nxt = push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            evt_valid <= 1'b0;
            evt_ts    <= '0;
            evt_v     <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr_inc;
            end
            occ       <= occ_nxt;
            evt_valid <= (occ_nxt != '0);
            {evt_ts, evt_v} <= head_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spike_count <= '0;
            overflow    <= 1'b0;
        end else if (clr_count) begin
            spike_count <= detect ? 16'd1 : 16'd0;
            overflow    <= drop;
        end else begin
            if (detect && (spike_count != 16'hFFFF)) begin
                spike_count <= spike_count + 16'd1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_spike_event_encoder.sv
// tb/tb_spike_event_encoder.sv - directed self-checking bench for spike_event_encoder
module tb_spike_event_encoder;
    logic        clk = 1'b0;
    logic        rst, en, clr_count, evt_ready;
    logic [15:0] v_in, thresh, rearm_level;

    logic        a_valid, b_valid, a_ovf, b_ovf;
    logic [15:0] a_ts, a_v, b_v, a_cnt, b_cnt;
    logic [3:0]  b_ts;

    int n_checks = 0;
    int n_pass   = 0;
    logic [15:0] tsm;
    logic [15:0] first_ts, second_ts, hold_ts;
    int          seen;

    always #5 clk = ~clk;

    // Default parameters: refractory 4, 16-bit timestamps.
    spike_event_encoder u_a (
        .clk(clk), .rst(rst), .en(en), .v_in(v_in), .thresh(thresh),
        .rearm_level(rearm_level), .clr_count(clr_count),
        .evt_valid(a_valid), .evt_ready(evt_ready), .evt_ts(a_ts), .evt_v(a_v),
        .spike_count(a_cnt), .overflow(a_ovf)
    );

    // No refractory, 4-bit timestamps for overflow and wrap cases.
    spike_event_encoder #(.TS_WIDTH(4), .REFRAC_CYCLES(0)) u_b (
        .clk(clk), .rst(rst), .en(en), .v_in(v_in), .thresh(thresh),
        .rearm_level(rearm_level), .clr_count(clr_count),
        .evt_valid(b_valid), .evt_ready(evt_ready), .evt_ts(b_ts), .evt_v(b_v),
        .spike_count(b_cnt), .overflow(b_ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Timestamp model: counts enabled edges since reset.
    task automatic tick();
        @(posedge clk);
        if (en) tsm = tsm + 16'd1;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tsm = '0;
    endtask

    task automatic toggle_detects(input int n_ticks);
        for (int i = 0; i < n_ticks; i++) begin
            v_in = (i % 2 == 0) ? 16'h1200 : 16'hF000;
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; clr_count = 1'b0; evt_ready = 1'b1;
        v_in = 16'h0000; thresh = 16'h1000; rearm_level = 16'h0000;
        tsm = '0;
        do_reset();
        check("rst_valid", {31'd0, a_valid}, 32'd0);
        check("rst_ts",    {16'd0, a_ts},    32'd0);
        check("rst_v",     {16'd0, a_v},     32'd0);
        check("rst_cnt",   {16'd0, a_cnt},   32'd0);
        check("rst_ovf",   {31'd0, a_ovf},   32'd0);

        // Basic spike at ts=5, threshold met exactly.
        en = 1'b1; v_in = 16'h0F00;
        repeat (5) tick();
        check("below_thresh", {31'd0, a_valid}, 32'd0);
        v_in = 16'h1000;
        tick();
        check("basic_valid", {31'd0, a_valid}, 32'd1);
        check("basic_ts",    {16'd0, a_ts},    32'd5);
        check("basic_v",     {16'd0, a_v},     32'h1000);
        check("basic_cnt",   {16'd0, a_cnt},   32'd1);
        v_in = 16'hFF00;
        tick();
        check("basic_popped", {31'd0, a_valid}, 32'd0);
        check("empty_ts",     {16'd0, a_ts},    32'd0);

        // Refractory + hysteresis: one event for a long excursion.
        repeat (5) tick();
        evt_ready = 1'b0; v_in = 16'h1200;
        first_ts = tsm;
        repeat (20) tick();
        check("hold_cnt",   {16'd0, a_cnt}, 32'd2);
        check("hold_head",  {16'd0, a_ts},  {16'd0, first_ts});
        v_in = 16'hFF00;
        tick();
        v_in = 16'h1200;
        second_ts = tsm;
        tick();
        check("rearm_cnt", {16'd0, a_cnt}, 32'd3);
        evt_ready = 1'b1;
        tick();
        check("second_ts", {16'd0, a_ts}, {16'd0, second_ts});
        check("gap", {31'd0, (a_ts - first_ts) >= 16'd6}, 32'd1);
        tick();
        check("drained_a", {31'd0, a_valid}, 32'd0);

        // Overflow: 10 detects into an 8-deep queue.
        do_reset();
        evt_ready = 1'b0;
        toggle_detects(16);
        check("full_no_ovf", {31'd0, b_ovf}, 32'd0);
        toggle_detects(4);
        check("ovf_set",  {31'd0, b_ovf}, 32'd1);
        check("ovf_cnt",  {16'd0, b_cnt}, 32'd10);
        check("ovf_head_v", {16'd0, b_v}, 32'h1200);
        v_in = 16'h0000; evt_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("drain_ts%0d", k), {28'd0, b_ts}, 2 * k);
            tick();
        end
        check("drain_empty", {31'd0, b_valid}, 32'd0);

        // Full queue with simultaneous push and pop.
        clr_count = 1'b1;
        tick();
        clr_count = 1'b0;
        check("clr_ovf", {31'd0, b_ovf}, 32'd0);
        check("clr_cnt", {16'd0, b_cnt}, 32'd0);
        evt_ready = 1'b0;
        toggle_detects(16);
        evt_ready = 1'b1; v_in = 16'h1200;
        tick();
        check("pp_ovf", {31'd0, b_ovf}, 32'd0);
        check("pp_cnt", {16'd0, b_cnt}, 32'd9);
        v_in = 16'h0000;
        seen = 0;
        for (int j = 0; j < 12; j++) begin
            if (b_valid) seen++;
            tick();
        end
        check("pp_occupancy", seen, 32'd8);

        // Enable gating freezes detection and ts.
        v_in = 16'hF000;
        tick();
        en = 1'b0; v_in = 16'h1200;
        hold_ts = tsm;
        repeat (3) tick();
        check("en0_cnt",   {16'd0, b_cnt},   32'd9);
        check("en0_valid", {31'd0, b_valid}, 32'd0);
        en = 1'b1;
        tick();
        check("en1_ts", {28'd0, b_ts}, {28'd0, hold_ts[3:0]});
        v_in = 16'hF000;
        tick();
        for (int j = 0; j < 20 && tsm[3:0] != 4'd0; j++) tick();
        v_in = 16'h1200;
        tick();
        check("wrap_valid", {31'd0, b_valid}, 32'd1);
        check("wrap_ts",    {28'd0, b_ts},    32'd0);
        check("wrap_v",     {16'd0, b_v},     32'h1200);

        // Asynchronous reset mid-drain.
        do_reset();
        evt_ready = 1'b0;
        toggle_detects(6);
        check("three_queued", {16'd0, b_cnt}, 32'd3);
        evt_ready = 1'b1; v_in = 16'h0000;
        tick();
        #3 rst = 1'b1;
        #1;
        check("arst_valid", {31'd0, b_valid}, 32'd0);
        check("arst_ts",    {28'd0, b_ts},    32'd0);
        check("arst_v",     {16'd0, b_v},     32'd0);
        check("arst_cnt",   {16'd0, b_cnt},   32'd0);
        tick();
        rst = 1'b0;
        tsm = '0;

        // clr_count versus coincident detect.
        evt_ready = 1'b0;
        toggle_detects(20);
        check("pre_clr_ovf", {31'd0, b_ovf}, 32'd1);
        v_in = 16'h1200; clr_count = 1'b1;
        tick();
        check("clr_drop_cnt", {16'd0, b_cnt}, 32'd1);
        check("clr_drop_ovf", {31'd0, b_ovf}, 32'd1);
        v_in = 16'hF000;
        tick();
        check("clr_only_cnt", {16'd0, b_cnt}, 32'd0);
        check("clr_only_ovf", {31'd0, b_ovf}, 32'd0);
        v_in = 16'h1200; evt_ready = 1'b1;
        tick();
        clr_count = 1'b0;
        check("clr_det_cnt", {16'd0, b_cnt}, 32'd1);
        check("clr_det_ovf", {31'd0, b_ovf}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
